matmul_engine: RTL
==================

Name: matmul_engine

Overview:
- Parametrised matrix-multiply sequencer: successor to the fixed 8-bit X/Y/Z processor datapath.
- Computes C = A × B over a shared single-port data memory, for any runtime dimensions up to MAX_DIM.
- A is X×Y at base_a, B is Y×Z at base_b, C is X×Z at base_c, all row-major.
- Sits beside the instruction-driven processor: the processor writes dimensions and bases, pulses start, and waits for done. The engine owns dm_* only while busy.

Parameters:
DATA_W, 8, element width in memory (signed two's complement)
ACC_W, 24, accumulator width
ADDR_W, 16, data-memory address width
MAX_DIM, 16, maximum legal value of each of X, Y, Z

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request, sampled only in IDLE
dim_x  in  $clog2(MAX_DIM+1)  rows of A
dim_y  in  $clog2(MAX_DIM+1)  cols of A / rows of B
dim_z  in  $clog2(MAX_DIM+1)  cols of B
base_a  in  ADDR_W  base address of A
base_b  in  ADDR_W  base address of B
base_c  in  ADDR_W  base address of C
dm_rdata  in  DATA_W  read data, valid one cycle after a read
dm_en  out  1  memory access strobe
dm_we  out  1  1 = write, 0 = read
dm_addr  out  ADDR_W  access address
dm_wdata  out  DATA_W  write data
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky illegal-dimension flag, cleared by the next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE; dm_en, dm_we, busy, done, err = 0; dm_addr, dm_wdata, accumulator and counters = 0. Deasserting reset mid-operation leaves the engine in IDLE, with no further memory access.
- States: IDLE, RD_A, RD_B, MAC, WR, FIN.
- IDLE:
  - On start=1, latch dims and bases and clear err.
  - If any dim is 0 or any dim > MAX_DIM: set err=1, go to FIN. No memory access is made.
  - Otherwise set i=j=k=0, clear acc, go to RD_A.
- RD_A: dm_en=1, dm_we=0, dm_addr = base_a + i*Y + k.
- RD_B: dm_en=1, dm_we=0, dm_addr = base_b + k*Z + j. Latch dm_rdata as a.
- MAC:
  - dm_en=0. Latch dm_rdata as b.
  - acc <= acc + sext(a)*sext(b), modulo 2^ACC_W.
  - If k == Y-1, go to WR; else k++ and go to RD_A.
- WR:
  - dm_en=1, dm_we=1, dm_addr = base_c + i*Z + j.
  - dm_wdata = acc[DATA_W-1:0] (truncated).
  - Then clear acc and set k=0.
  - Advance j; on wrap, j=0 and i++.
  - If the last element (i=X-1, j=Z-1) was written, go to FIN; else go to RD_A.
- FIN: done=1 for exactly one cycle, then IDLE.
- Outputs are registered. The dm_* values listed above are those presented during the cycle the FSM is in that state.
- busy = 1 in RD_A, RD_B, MAC and WR; 0 in IDLE and FIN.
- Latency:
  - Each C element takes 3Y+1 cycles.
  - busy is high for X·Z·(3Y+1) cycles, starting the cycle after start.
  - done follows the last WR by one cycle.
- Address arithmetic wraps modulo 2^ADDR_W. Offsets are computed by incremental row/column pointers (no multiplier in the address path).
- start while busy or in FIN is ignored.
- Dims and bases changing while busy have no effect.
- dm_addr and dm_wdata hold their last value when dm_en=0.

Optional Feature:
- Macro: MATMUL_SATURATE_EN.
- Defined: WR stores acc clamped to the signed DATA_W range, i.e. [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Not defined: WR stores acc[DATA_W-1:0] (truncation).
- The accumulator itself wraps in both cases.

Test Plan:
- 2×2×2, A=[1 2;3 4], B=[5 6;7 8] -> C=[19 22;43 50] written at base_c..base_c+3; busy high 28 cycles; one done pulse.
- 1×3×1 with bases at 0xFFFE (A), 0x0010 (B), 0x0020 (C); A=[1 1 1], B=[2 3 4] -> C=9; A addresses wrap 0xFFFE, 0xFFFF, 0x0000.
- dim_y=0, and separately dim_x=MAX_DIM+1 -> err=1, done pulse 1 cycle after start, dm_en never asserted, busy stays 0.
- 1×2×1, A=[100 100], B=[100 100] (acc=20000):
  - without the macro -> stored 0x20;
  - with MATMUL_SATURATE_EN -> stored 0x7F;
  - with A=[-100 100], B=[100 -100] -> 0xE0 without the macro, 0x80 with it.
- Second start pulsed during a 2×2×2 run -> ignored; result unchanged, exactly one done pulse.
- rst asserted during the third MAC of a 3×3×3 run -> all outputs 0 immediately, state IDLE; a fresh start after release completes correctly.

Source files
------------

// File: rtl/matmul_engine_if.sv
// Bus bundle between matmul_engine and its surroundings: the processor-side
// job controls (start, dimensions, bases, status) plus the data-memory port.
// The master modport is the engine's view; the slave modport is the view of
// the processor/memory side that drives the job and answers reads.
interface matmul_engine_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int MAX_DIM = 16
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);

  logic              start;
  logic [DIM_W-1:0]  dim_x;
  logic [DIM_W-1:0]  dim_y;
  logic [DIM_W-1:0]  dim_z;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_c;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_en;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, dim_x, dim_y, dim_z, base_a, base_b, base_c, dm_rdata,
    output dm_en, dm_we, dm_addr, dm_wdata, busy, done, err
  );

  modport slave (
    output start, dim_x, dim_y, dim_z, base_a, base_b, base_c, dm_rdata,
    input  dm_en, dm_we, dm_addr, dm_wdata, busy, done, err
  );
endinterface

// File: rtl/matmul_engine.sv
// matmul_engine: sequences C = A x B (row-major, signed DATA_W elements) over a
// shared single-port data memory. Each C element costs Y x (read A, read B,
// multiply-accumulate) plus one write cycle. All outputs are registered and
// are computed from the next state so they line up with the state they belong to.
// Optional build macro MATMUL_SATURATE_EN: when defined, stored C elements are
// clamped to the signed DATA_W range instead of truncated.
module matmul_engine #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int ADDR_W  = 16,
  parameter int MAX_DIM = 16
) (
  input  logic            clock,
  input  logic            rst,
  matmul_engine_if.master bus
);
  localparam int DIM_W  = $clog2(MAX_DIM + 1);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, FIN} state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  // a_row = base_a + i*Y, a_ptr = a_row + k, b_col = base_b + j,
  // b_ptr = b_col + k*Z, c_ptr = base_c + i*Z + j (C is written sequentially).
  logic [ADDR_W-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_col_q, b_col_d, b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d;
  logic              dm_en_q, dm_en_d, dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic                     dims_bad, k_last, j_last, i_last;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [DIM_W-1:0]         y_step_dim;
  logic [ADDR_W-1:0]        y_step, z_step;
  logic [DATA_W-1:0]        store_val;

  assign dims_bad = (bus.dim_x == '0) || (bus.dim_x > DIM_W'(MAX_DIM)) ||
                    (bus.dim_y == '0) || (bus.dim_y > DIM_W'(MAX_DIM)) ||
                    (bus.dim_z == '0) || (bus.dim_z > DIM_W'(MAX_DIM));
  assign k_last = (k_q == y_q - DIM_W'(1));
  assign j_last = (j_q == z_q - DIM_W'(1));
  assign i_last = (i_q == x_q - DIM_W'(1));

  // B operand is consumed straight from the memory read port during MAC.
  assign prod       = $signed(a_q) * $signed(bus.dm_rdata);
  assign prod_ext   = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign y_step_dim = y_q;
  assign y_step     = ADDR_W'(y_step_dim);
  assign z_step     = ADDR_W'(z_q);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = dims_bad ? FIN : RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = MAC;
      MAC:     state_d = k_last ? WR : RD_A;
      WR:      state_d = (i_last && j_last) ? FIN : RD_A;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job latching, loop counters, incremental address pointers and accumulator.
  always_comb begin
    x_d = x_q;  y_d = y_q;  z_d = z_q;
    i_d = i_q;  j_d = j_q;  k_d = k_q;
    base_b_d = base_b_q;
    a_row_d = a_row_q;  a_ptr_d = a_ptr_q;
    b_col_d = b_col_q;  b_ptr_d = b_ptr_q;
    c_ptr_d = c_ptr_q;
    a_d = a_q;  acc_d = acc_q;  err_d = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        x_d = bus.dim_x;  y_d = bus.dim_y;  z_d = bus.dim_z;
        err_d = dims_bad;
        i_d = '0;  j_d = '0;  k_d = '0;  acc_d = '0;
        base_b_d = bus.base_b;
        a_row_d = bus.base_a;  a_ptr_d = bus.base_a;
        b_col_d = bus.base_b;  b_ptr_d = bus.base_b;
        c_ptr_d = bus.base_c;
      end
      RD_B: a_d = bus.dm_rdata;
      MAC: begin
        acc_d = acc_q + prod_ext;
        if (!k_last) begin
          k_d     = k_q + DIM_W'(1);
          a_ptr_d = a_ptr_q + ADDR_W'(1);
          b_ptr_d = b_ptr_q + z_step;
        end
      end
      WR: begin
        acc_d   = '0;
        k_d     = '0;
        c_ptr_d = c_ptr_q + ADDR_W'(1);
        if (j_last) begin
          j_d     = '0;
          i_d     = i_q + DIM_W'(1);
          a_row_d = a_row_q + y_step;
          a_ptr_d = a_row_q + y_step;
          b_col_d = base_b_q;
          b_ptr_d = base_b_q;
        end else begin
          j_d     = j_q + DIM_W'(1);
          a_ptr_d = a_row_q;
          b_col_d = b_col_q + ADDR_W'(1);
          b_ptr_d = b_col_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef MATMUL_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic [ACC_W-1:0] SAT_LO = ~SAT_HI;

  // Clamp the finished sum to the signed element range.
  always_comb begin
    store_val = acc_d[DATA_W-1:0];
    if ($signed(acc_d) > $signed(SAT_HI))      store_val = DATA_W'(SAT_HI);
    else if ($signed(acc_d) < $signed(SAT_LO)) store_val = DATA_W'(SAT_LO);
  end
`else
  // Keep the low element bits of the finished sum.
  always_comb begin
    store_val = acc_d[DATA_W-1:0];
  end
`endif

  // Registered outputs derived from the upcoming state; address/data hold otherwise.
  always_comb begin
    dm_en_d    = (state_d == RD_A) || (state_d == RD_B) || (state_d == WR);
    dm_we_d    = (state_d == WR);
    busy_d     = dm_en_d || (state_d == MAC);
    done_d     = (state_d == FIN);
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    case (state_d)
      RD_A:    dm_addr_d = a_ptr_d;
      RD_B:    dm_addr_d = b_ptr_d;
      WR: begin
        dm_addr_d  = c_ptr_d;
        dm_wdata_d = store_val;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      x_q <= '0;  y_q <= '0;  z_q <= '0;
      i_q <= '0;  j_q <= '0;  k_q <= '0;
      base_b_q <= '0;
      a_row_q <= '0;  a_ptr_q <= '0;
      b_col_q <= '0;  b_ptr_q <= '0;
      c_ptr_q <= '0;
      a_q <= '0;  acc_q <= '0;  err_q <= 1'b0;
      dm_en_q <= 1'b0;  dm_we_q <= 1'b0;
      dm_addr_q <= '0;  dm_wdata_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      x_q <= x_d;  y_q <= y_d;  z_q <= z_d;
      i_q <= i_d;  j_q <= j_d;  k_q <= k_d;
      base_b_q <= base_b_d;
      a_row_q <= a_row_d;  a_ptr_q <= a_ptr_d;
      b_col_q <= b_col_d;  b_ptr_q <= b_ptr_d;
      c_ptr_q <= c_ptr_d;
      a_q <= a_d;  acc_q <= acc_d;  err_q <= err_d;
      dm_en_q <= dm_en_d;  dm_we_q <= dm_we_d;
      dm_addr_q <= dm_addr_d;  dm_wdata_q <= dm_wdata_d;
      busy_q <= busy_d;  done_q <= done_d;
    end
  end

  assign bus.dm_en    = dm_en_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule
